// File: rtl/shift_seq_pkg.sv
// -----------------------------------------------------------------------------
// shift_seq_pkg
// Shared definitions for the shift sequencer:
//   NREQ       - number of requesters (fixed at 2)
//   state_t    - controller FSM states (PARITY is only reachable when
//                SHIFT_SEQ_PARITY_EN is defined)
//   cnt_width  - bit counter width for a given data word width
// -----------------------------------------------------------------------------
package shift_seq_pkg;

    localparam int NREQ = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        DONE   = 2'd2,
        PARITY = 2'd3
    } state_t;

    // The counter must be able to hold WIDTH itself, hence WIDTH+1.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// shift_seq_ctrl_if
// Request/serial bundle of the shift sequencer.
//   req_valid[1:0]  requester word-available flags
//   req_data0/1     words from requester 0/1
//   req_ready[1:0]  per-requester accept
//   ser_out         serial bit, MSB first
//   ser_valid       ser_out carries a valid bit
//   ser_id          owner of the current serial stream
//   done            one-cycle end-of-stream pulse
//   busy            controller not idle
// Modports: master = requester/consumer side, slave = sequencer side.
// -----------------------------------------------------------------------------
interface shift_seq_ctrl_if #(
    parameter int WIDTH = 32
);
    import shift_seq_pkg::*;

    logic [NREQ-1:0]  req_valid;
    logic [WIDTH-1:0] req_data0;
    logic [WIDTH-1:0] req_data1;
    logic [NREQ-1:0]  req_ready;
    logic             ser_out;
    logic             ser_valid;
    logic             ser_id;
    logic             done;
    logic             busy;

    modport master (
        output req_valid, req_data0, req_data1,
        input  req_ready, ser_out, ser_valid, ser_id, done, busy
    );

    modport slave (
        input  req_valid, req_data0, req_data1,
        output req_ready, ser_out, ser_valid, ser_id, done, busy
    );

endinterface

// File: rtl/shift_seq_core.sv
// -----------------------------------------------------------------------------
// shift_seq_core
// Loadable WIDTH-bit left-shift register with zero fill.
//   clk, rst  clock, synchronous active-high reset
//   load      capture din (lower priority than clear)
//   shift     shift left by one, zero fill (lowest priority)
//   clear     force register to zero
//   din       word to load
//   msb       current most significant bit
// -----------------------------------------------------------------------------
module shift_seq_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    output logic             msb
);

    logic [WIDTH-1:0] sreg;

    // NOTE: registers use non-blocking assignments so every flop samples
    // pre-edge values, regardless of the order processes are evaluated in.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            sreg <= '0;
        end else if (load) begin
            sreg <= din;
        end else if (shift) begin
            sreg <= {sreg[WIDTH-2:0], 1'b0};
        end
    end

    assign msb = sreg[WIDTH-1];

endmodule

// File: rtl/shift_seq_ctrl.sv
// -----------------------------------------------------------------------------
// shift_seq_ctrl
// Two-requester round-robin arbiter feeding a parallel-to-serial shifter.
// A granted word is sent MSB first over WIDTH cycles, followed by a one-cycle
// done pulse. Optional macro SHIFT_SEQ_PARITY_EN inserts one extra serial bit
// carrying the even parity (XOR) of the word before done.
//   clk, rst  clock, synchronous active-high reset
//   bus       shift_seq_ctrl_if slave modport (requests in, serial out)
// -----------------------------------------------------------------------------
module shift_seq_ctrl
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    shift_seq_ctrl_if.slave  bus
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    state_t           state_nx;
    logic             ptr;
    logic             id_q;
    logic [CW-1:0]    cnt;
    logic             winner;
    logic             any_valid;
    logic             load;
    logic             shift;
    logic             clear;
    logic             msb;
    logic             last_bit;
    logic [WIDTH-1:0] din;
    logic [NREQ-1:0]  ready;
    logic             ser_out;
    logic             ser_valid;
    logic             done;
`ifdef SHIFT_SEQ_PARITY_EN
    logic             parity_q;
`endif

    // Lone requester always wins; on contention the pointer decides.
    assign any_valid = |bus.req_valid;
    assign winner    = (bus.req_valid[0] && bus.req_valid[1]) ? ptr : bus.req_valid[1];
    assign din       = winner ? bus.req_data1 : bus.req_data0;
    assign load      = !rst && (state == IDLE) && any_valid;
    assign last_bit  = (cnt == CW'(WIDTH - 1));

    shift_seq_core #(.WIDTH(WIDTH)) u_core (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .shift (shift),
        .clear (clear),
        .din   (din),
        .msb   (msb)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= 1'b0;
            id_q     <= 1'b0;
            cnt      <= '0;
`ifdef SHIFT_SEQ_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            if (load) begin
                ptr      <= ~winner;
                id_q     <= winner;
                cnt      <= '0;
`ifdef SHIFT_SEQ_PARITY_EN
                parity_q <= ^din;
`endif
            end else if (shift) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave a value held and infer a latch.
    always_comb begin
        state_nx  = state;
        shift     = 1'b0;
        clear     = 1'b0;
        ready     = '0;
        ser_out   = 1'b0;
        ser_valid = 1'b0;
        done      = 1'b0;
        // Outputs are forced low for the whole reset cycle, not just after it.
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        ready    = winner ? 2'b10 : 2'b01;
                        state_nx = SHIFT;
                    end
                end
                SHIFT: begin
                    ser_valid = 1'b1;
                    ser_out   = msb;
                    shift     = 1'b1;
                    if (last_bit) begin
`ifdef SHIFT_SEQ_PARITY_EN
                        state_nx = PARITY;
`else
                        state_nx = DONE;
`endif
                    end
                end
`ifdef SHIFT_SEQ_PARITY_EN
                PARITY: begin
                    ser_valid = 1'b1;
                    ser_out   = parity_q;
                    state_nx  = DONE;
                end
`endif
                DONE: begin
                    done     = 1'b1;
                    clear    = 1'b1;
                    state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    assign bus.req_ready = ready;
    assign bus.ser_out   = ser_out;
    assign bus.ser_valid = ser_valid;
    assign bus.done      = done;
    assign bus.ser_id    = rst ? 1'b0 : id_q;
    assign bus.busy      = !rst && (state != IDLE);

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_shift_seq_ctrl
// Self-checking bench for shift_seq_ctrl with WIDTH=8. A vector table covers
// reset and a single A5 stream; hand-written sequences cover interleaving,
// reset mid-stream, data changes while shifting and the parity option
// (expectations follow SHIFT_SEQ_PARITY_EN when it is defined).
// -----------------------------------------------------------------------------
module tb_shift_seq_ctrl;

    localparam int W = 8;
`ifdef SHIFT_SEQ_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int P = W + 2 + PAR;  // transfer-to-transfer spacing

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    shift_seq_ctrl_if #(.WIDTH(W)) bus ();

    shift_seq_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic       r;
        logic [1:0] v;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [1:0] e_rdy;
        logic       e_sv;
        logic       e_so;
        logic       e_id;
        logic       e_done;
        logic       e_busy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic [1:0] v,
                                input logic [7:0] d0, input logic [7:0] d1,
                                input logic [1:0] e_rdy, input logic e_sv,
                                input logic e_so, input logic e_id,
                                input logic e_done, input logic e_busy);
        vec_t t;
        t.r = r; t.v = v; t.d0 = d0; t.d1 = d1;
        t.e_rdy = e_rdy; t.e_sv = e_sv; t.e_so = e_so;
        t.e_id = e_id; t.e_done = e_done; t.e_busy = e_busy;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [1:0] rdy, input logic sv,
                             input logic so, input logic id, input logic dn, input logic bs);
        check({tag, " req_ready"}, 32'(bus.req_ready), 32'(rdy));
        check({tag, " ser_valid"}, 32'(bus.ser_valid), 32'(sv));
        check({tag, " ser_out"},   32'(bus.ser_out),   32'(so));
        check({tag, " ser_id"},    32'(bus.ser_id),    32'(id));
        check({tag, " done"},      32'(bus.done),      32'(dn));
        check({tag, " busy"},      32'(bus.busy),      32'(bs));
    endtask

    // Inputs change just after the rising edge; outputs are read at the
    // following falling edge.
    task automatic drive(input logic r, input logic [1:0] v,
                         input logic [7:0] d0, input logic [7:0] d1);
        @(posedge clk);
        #1;
        rst           = r;
        bus.req_valid = v;
        bus.req_data0 = d0;
        bus.req_data1 = d1;
        @(negedge clk);
    endtask

    // Expected serial bit k cycles after the transfer of word.
    function automatic logic exp_bit(input logic [7:0] word, input int k);
        if (k >= 1 && k <= W) return word[W-k];
        if (PAR == 1 && k == W + 1) return ^word;
        return 1'b0;
    endfunction

    // One full stream: transfer cycle then P-1 further cycles, with the given
    // (ignored) inputs applied while the controller is busy.
    task automatic stream(input string tag, input logic [1:0] v, input logic [7:0] d0,
                          input logic [7:0] d1, input logic [7:0] word, input logic id,
                          input logic prev_id, input logic [1:0] v_busy,
                          input logic [7:0] d0_busy, input logic [7:0] d1_busy);
        drive(1'b0, v, d0, d1);
        check_all($sformatf("%s k0", tag), id ? 2'b10 : 2'b01, 1'b0, 1'b0, prev_id, 1'b0, 1'b0);
        for (int k = 1; k < P; k++) begin
            drive(1'b0, v_busy, d0_busy, d1_busy);
            check_all($sformatf("%s k%0d", tag, k), 2'b00, (k <= W + PAR), exp_bit(word, k),
                      id, (k == P - 1), 1'b1);
        end
    endtask

    initial begin
        logic [7:0] a5;
        logic [7:0] word;
        logic       id;
        int         s;
        int         k;

        bus.req_valid = '0;
        bus.req_data0 = '0;
        bus.req_data1 = '0;
        a5 = 8'hA5;

        // Reset with both requesters valid, then a single A5 stream.
        tbl.push_back(mk(1, 2'b11, 8'h00, 8'h00, 2'b00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 2'b11, 8'h00, 8'h00, 2'b00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 2'b01, a5,    8'h00, 2'b01, 0, 0, 0, 0, 0));
        for (int i = 1; i <= W; i++)
            tbl.push_back(mk(0, 2'b00, 8'h00, 8'h00, 2'b00, 1, a5[W-i], 0, 0, 1));
`ifdef SHIFT_SEQ_PARITY_EN
        tbl.push_back(mk(0, 2'b00, 8'h00, 8'h00, 2'b00, 1, 0, 0, 0, 1));
`endif
        tbl.push_back(mk(0, 2'b00, 8'h00, 8'h00, 2'b00, 0, 0, 0, 1, 1));
        tbl.push_back(mk(0, 2'b00, 8'h00, 8'h00, 2'b00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 2'b10, 8'h00, 8'h80, 2'b10, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 2'b00, 8'h00, 8'h80, 2'b00, 1, 1, 1, 0, 1));

        foreach (tbl[i]) begin
            drive(tbl[i].r, tbl[i].v, tbl[i].d0, tbl[i].d1);
            check_all($sformatf("vec%0d", i), tbl[i].e_rdy, tbl[i].e_sv, tbl[i].e_so,
                      tbl[i].e_id, tbl[i].e_done, tbl[i].e_busy);
        end

        // Reset aborts the requester-1 stream above and clears the pointer.
        drive(1'b1, 2'b00, 8'h00, 8'h00);
        drive(1'b0, 2'b00, 8'h00, 8'h00);
        check_all("post_rst", 2'b00, 0, 0, 0, 0, 0);

        // Both valid and held: grants alternate 0,1 with spacing P.
        for (int c = 0; c < 2 * P; c++) begin
            drive(1'b0, 2'b11, 8'hFF, 8'h0F);
            s    = c / P;
            k    = c % P;
            id   = (s % 2 == 1);
            word = id ? 8'h0F : 8'hFF;
            check_all($sformatf("ilv c%0d", c),
                      (k == 0) ? (id ? 2'b10 : 2'b01) : 2'b00,
                      (k >= 1 && k <= W + PAR), exp_bit(word, k),
                      (k == 0) ? 1'b0 : id, (k == P - 1), (k != 0));
        end
        drive(1'b0, 2'b00, 8'h00, 8'h00);
        check_all("ilv idle", 2'b00, 0, 0, 1, 0, 0);

        // Reset during the 4th bit of C3: stream discarded, no done pulse.
        drive(1'b0, 2'b01, 8'hC3, 8'h00);
        check_all("abort k0", 2'b01, 0, 0, 1, 0, 0);
        for (int i = 1; i <= 3; i++) begin
            drive(1'b0, 2'b00, 8'h00, 8'h00);
            check_all($sformatf("abort k%0d", i), 2'b00, 1, exp_bit(8'hC3, i), 0, 0, 1);
        end
        drive(1'b1, 2'b00, 8'h00, 8'h00);
        for (int i = 0; i < P; i++) begin
            drive(1'b0, 2'b00, 8'h00, 8'h00);
            check_all($sformatf("abort idle%0d", i), 2'b00, 0, 0, 0, 0, 0);
        end

        // Pointer restarted at 0 (it was 1 before reset): requester 0 wins.
        stream("rr_after_rst", 2'b11, 8'h11, 8'h22, 8'h11, 1'b0, 1'b0, 2'b00, 8'h00, 8'h00);
        stream("lone_req1",    2'b10, 8'h00, 8'h3C, 8'h3C, 1'b1, 1'b0, 2'b00, 8'h00, 8'h00);

        // Inputs change while shifting: the accepted 81 is sent unchanged.
        stream("data_chg", 2'b01, 8'h81, 8'h00, 8'h81, 1'b0, 1'b1, 2'b11, 8'h7E, 8'h7E);
        drive(1'b0, 2'b00, 8'h00, 8'h00);
        check_all("data_chg idle", 2'b00, 0, 0, 0, 0, 0);

        // 07: done after 8 bits, or after 8 bits plus parity bit 1.
        stream("par07", 2'b01, 8'h07, 8'h00, 8'h07, 1'b0, 1'b0, 2'b00, 8'h00, 8'h00);
        drive(1'b0, 2'b00, 8'h00, 8'h00);
        check_all("par07 idle", 2'b00, 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_seq_ctrl.md
SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 Parameter WIDTH, default 32: data word width, minimum 2.
REQ-002 Parameter NREQ, fixed at 2: number of requesters.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  2  per-requester word-available flag.
REQ-006 req_data0  input  WIDTH  word from requester 0.
REQ-007 req_data1  input  WIDTH  word from requester 1.
REQ-008 req_ready  output  2  per-requester accept; transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-009 ser_out  output  1  serial bit, MSB first.
REQ-010 ser_valid  output  1  ser_out carries a valid bit this cycle.
REQ-011 ser_id  output  1  index of the requester owning the current serial stream.
REQ-012 done  output  1  one-cycle pulse marking end of a stream.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 FSM states: IDLE, SHIFT, DONE; PARITY is added only under REQ-026.
REQ-015 IDLE: req_ready is combinational and one-hot to the arbitration winner; it is zero in all other states.
REQ-016 Arbitration: round-robin with a 1-bit priority pointer; a lone valid requester always wins; if both are valid, the pointer's requester wins.
REQ-017 After each accepted transfer, the pointer moves to the requester that did not win.
REQ-018 On a transfer in cycle N: word loaded into the shift register, ser_id set to the winner, and state moves to SHIFT at N+1.
REQ-019 SHIFT: ser_valid=1 for exactly WIDTH cycles (N+1..N+WIDTH); ser_out = current MSB; the register shifts left by one each cycle with zero fill.
REQ-020 Bit counter width is clog2(WIDTH+1); on the last bit the FSM moves to DONE with no wrap or extra cycle.
REQ-021 DONE: single cycle with done=1, ser_valid=0, then IDLE; a new transfer is possible in the following IDLE cycle, so minimum spacing is WIDTH+2 cycles.
REQ-022 Changes to req_valid or req_data outside IDLE are ignored; an in-flight word is never corrupted.
REQ-023 ser_out=0 whenever ser_valid=0.

Reset
REQ-024 With rst high: state=IDLE, shift register=0, counter=0, pointer=0, ser_out=0, ser_valid=0, ser_id=0, done=0, busy=0, req_ready=0.
REQ-025 Reset asserted mid-stream aborts the stream: the word is discarded, no done pulse is produced, and arbitration restarts from pointer=0 once rst is released.

Configuration
REQ-026 Macro SHIFT_SEQ_PARITY_EN. When defined, a PARITY state is inserted between SHIFT and DONE: one extra cycle with ser_valid=1 and ser_out = even parity (XOR) of the accepted word, giving minimum spacing of WIDTH+3. When undefined, no PARITY state or parity logic exists, and behaviour is exactly REQ-014..REQ-023.

Structure
REQ-027 Package shift_seq_pkg holds: the FSM state typedef (IDLE, SHIFT, DONE, PARITY), the NREQ constant, and a clog2-based counter-width function.
REQ-028 One sub-module, shift_seq_core: the loadable WIDTH-bit left-shift register with load, shift and clear controls, exposing its MSB; the arbiter and FSM stay in shift_seq_ctrl.

Verification (WIDTH=8)
REQ-029 Single request: req_valid=01, req_data0=8'hA5 -> ready[0] high for one cycle; ser_out 1,0,1,0,0,1,0,1 over 8 cycles with ser_id=0; done pulses at cycle 9; busy low at cycle 10.
REQ-030 Simultaneous requests: req_valid=11 held, data0=8'hFF, data1=8'h0F -> streams interleave 0,1,0,1 by ser_id; each done is 10 cycles after the previous one.
REQ-031 Reset mid-stream: rst high at the 4th bit of 8'hC3 -> next cycle all outputs are 0, no done pulse; after release, req_valid=10 grants requester 1 first.
REQ-032 Data change during SHIFT: req_data0 switches from 8'h81 to 8'h7E after acceptance -> serial stream still 1,0,0,0,0,0,0,1.
REQ-033 With SHIFT_SEQ_PARITY_EN defined: 8'h07 -> 8 data bits followed by parity bit 1 with ser_valid=1, done at cycle 10. Without the macro, the same stimulus gives done at cycle 9.
